// File: rtl/fast_inv_sqrt_arbiter_pkg.sv
// Shared types and constants for the fastInvSqrt engine arbiter.
// Optional op counter is controlled by macro FISQRT_ARB_OPCOUNT_EN.
package fast_inv_sqrt_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int OP_COUNT_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Index width for a requester vector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fast_inv_sqrt_arbiter_if.sv
// Requester-side bus of the fastInvSqrt arbiter: operand request and
// result response handshakes for all requesters, one shared result bus.
// master = requester cluster, slave = arbiter.
interface fast_inv_sqrt_arbiter_if
    import fast_inv_sqrt_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [DATA_WIDTH-1:0]         rsp_data;

    modport master (
        output req_valid,
        output req_data,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/fast_inv_sqrt_arbiter_rr_arbiter.sv
// Combinational round-robin picker. The search starts one past the last
// granted index and wraps, so the most recently served requester has the
// lowest priority on the next pick.
module rr_arbiter
    import fast_inv_sqrt_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(DEF_NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    // Walk the rotated request vector and keep the first hit.
    always_comb begin
        int cand;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_grant) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!any && req[cand[IDX_W-1:0]]) begin
                any                     = 1'b1;
                grant_idx               = cand[IDX_W-1:0];
                grant[cand[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fast_inv_sqrt_arbiter.sv
// Shares one fastInvSqrt engine between NUM_REQ requesters with a single
// operation outstanding at a time. Optional completed-op counter is built
// only when FISQRT_ARB_OPCOUNT_EN is defined; otherwise op_count reads 0.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | arbitrate; winner sees req_ready, operand latched on edge
// ST_ISSUE | present latched operand to engine until eng_ready_in
// ST_WAIT  | eng_ready_out high, wait for engine result
// ST_RESP  | hold rsp_valid[grant_id]/rsp_data until rsp_ready[grant_id]
module fast_inv_sqrt_arbiter
    import fast_inv_sqrt_arb_pkg::*;
#(
    parameter int  NUM_REQ    = DEF_NUM_REQ,
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int IDX_W      = idx_width(NUM_REQ)
)(
    input  logic                    clk,
    input  logic                    rst_n,

    fast_inv_sqrt_arbiter_if.slave  bus,

    output logic                    eng_valid_in,
    input  logic                    eng_ready_in,
    output logic [DATA_WIDTH-1:0]   eng_data_in,
    input  logic                    eng_valid_out,
    output logic                    eng_ready_out,
    input  logic [DATA_WIDTH-1:0]   eng_data_out,

    output logic                    busy,
    output logic [IDX_W-1:0]        grant_id,
    output logic [OP_COUNT_W-1:0]   op_count
);

    arb_state_t                state_q;
    logic [IDX_W-1:0]          last_grant_q;
    logic [IDX_W-1:0]          grant_id_q;
    logic [DATA_WIDTH-1:0]     op_data_q;
    logic [DATA_WIDTH-1:0]     res_data_q;
    logic                      eng_valid_q;
    logic                      eng_ready_q;
    logic                      busy_q;
    logic [NUM_REQ-1:0]        rsp_valid_q;

    logic [NUM_REQ-1:0]        arb_grant;
    logic [IDX_W-1:0]          arb_idx;
    logic                      arb_any;
    logic                      rsp_hs;
    logic [DATA_WIDTH-1:0]     req_word [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    // The accept strobe is the only combinational output; it is also
    // forced low while reset is held so nothing looks accepted then.
    assign bus.req_ready = (state_q == ST_IDLE && rst_n) ? arb_grant : '0;

    // Only the owning requester can complete the response.
    assign rsp_hs = (state_q == ST_RESP) && bus.rsp_ready[grant_id_q];

    // Sequencer: state, latched operand/result and all handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            op_data_q    <= '0;
            res_data_q   <= '0;
            eng_valid_q  <= 1'b0;
            eng_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        op_data_q   <= req_word[arb_idx];
                        grant_id_q  <= arb_idx;
                        eng_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (eng_ready_in) begin
                        eng_valid_q <= 1'b0;
                        eng_ready_q <= 1'b1;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (eng_valid_out) begin
                        res_data_q  <= eng_data_out;
                        eng_ready_q <= 1'b0;
                        rsp_valid_q <= NUM_REQ'(1) << grant_id_q;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        rsp_valid_q  <= '0;
                        busy_q       <= 1'b0;
                        last_grant_q <= grant_id_q;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef FISQRT_ARB_OPCOUNT_EN
    logic [OP_COUNT_W-1:0] op_count_q;

    // Count completed responses; wraps naturally at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (rsp_hs) begin
            op_count_q <= op_count_q + OP_COUNT_W'(1);
        end
    end

    assign op_count = op_count_q;
`else
    assign op_count = '0;
`endif

    assign eng_valid_in  = eng_valid_q;
    assign eng_data_in   = op_data_q;
    assign eng_ready_out = eng_ready_q;
    assign busy          = busy_q;
    assign grant_id      = grant_id_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = res_data_q;

endmodule

// File: tb/tb_fast_inv_sqrt_arbiter.sv
// Bench for fast_inv_sqrt_arbiter: behavioural engine, vector table,
// hand-written corner sequences and a randomized phase with a rotation model.
module tb_fast_inv_sqrt_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
`ifdef FISQRT_ARB_OPCOUNT_EN
    localparam int EXP_ROT_OPC = 5;
`else
    localparam int EXP_ROT_OPC = 0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          eng_valid_in;
    logic          eng_ready_in  = 1'b0;
    logic [DW-1:0] eng_data_in;
    logic          eng_valid_out = 1'b0;
    logic          eng_ready_out;
    logic [DW-1:0] eng_data_out  = '0;
    logic          busy;
    logic [1:0]    grant_id;
    logic [31:0]   op_count;

    fast_inv_sqrt_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    fast_inv_sqrt_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .eng_valid_in  (eng_valid_in),
        .eng_ready_in  (eng_ready_in),
        .eng_data_in   (eng_data_in),
        .eng_valid_out (eng_valid_out),
        .eng_ready_out (eng_ready_out),
        .eng_data_out  (eng_data_out),
        .busy          (busy),
        .grant_id      (grant_id),
        .op_count      (op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Q12.4 reciprocal square root: 1/sqrt(x/16) * 16 = 64/sqrt(x), truncated.
    function automatic logic [DW-1:0] ref_isqrt(input logic [DW-1:0] x);
        real r;
        if (x == '0) return '1;
        r = 64.0 / $sqrt(real'(x));
        return DW'(int'($floor(r)));
    endfunction

    // Reference arbitration state: who was served last and how many ops.
    int m_last = N - 1;
    int m_ops  = 0;

    function automatic int model_pick(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic int exp_opc();
`ifdef FISQRT_ARB_OPCOUNT_EN
        return m_ops;
`else
        return 0;
`endif
    endfunction

    // Behavioural engine: accept after eng_acc_delay cycles, answer after eng_lat.
    int            eng_acc_delay = 0;
    int            eng_lat       = 0;
    bit            e_have;
    int            e_acc, e_lat_cnt;
    logic [DW-1:0] e_res, l_di;
    logic          l_vi, l_ri, l_vo, l_ro;

    always @(negedge clk) begin
        if (!rst_n) begin
            eng_ready_in  = 1'b0;
            eng_valid_out = 1'b0;
            eng_data_out  = '0;
            e_have = 1'b0; e_acc = 0; e_lat_cnt = 0; e_res = '0;
            l_vi = 1'b0; l_ri = 1'b0; l_vo = 1'b0; l_ro = 1'b0; l_di = '0;
        end else begin
            if (l_vi && !l_ri) begin
                check("eng_valid_hold", 64'(eng_valid_in), 64'(1));
                check("eng_data_hold", 64'(eng_data_in), 64'(l_di));
            end
            if (l_vi && l_ri) begin
                e_have = 1'b1; e_res = ref_isqrt(l_di); e_lat_cnt = eng_lat;
                eng_ready_in = 1'b0; e_acc = 0;
            end
            if (l_vo && l_ro) begin
                eng_valid_out = 1'b0; e_have = 1'b0; eng_data_out = DW'($urandom);
            end
            if (e_have && !eng_valid_out) begin
                if (e_lat_cnt == 0) begin
                    eng_valid_out = 1'b1; eng_data_out = e_res;
                end else begin
                    e_lat_cnt--;
                end
            end
            if (!e_have && eng_valid_in && !eng_ready_in) begin
                if (e_acc >= eng_acc_delay) eng_ready_in = 1'b1;
                else e_acc++;
            end
            l_vi = eng_valid_in; l_ri = eng_ready_in; l_vo = eng_valid_out;
            l_ro = eng_ready_out; l_di = eng_data_in;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     64'(busy), 64'(0));
        check({tag, "_eng_vin"},  64'(eng_valid_in), 64'(0));
        check({tag, "_eng_rout"}, 64'(eng_ready_out), 64'(0));
        check({tag, "_rsp_v"},    64'(bus.rsp_valid), 64'(0));
        check({tag, "_req_r"},    64'(bus.req_ready), 64'(0));
        check({tag, "_grant"},    64'(grant_id), 64'(0));
        check({tag, "_eng_din"},  64'(eng_data_in), 64'(0));
        check({tag, "_rsp_d"},    64'(bus.rsp_data), 64'(0));
        check({tag, "_opc"},      64'(op_count), 64'(0));
    endtask

    // One complete operation, starting from IDLE at the next falling edge.
    task automatic serve(input logic [N-1:0] mask, input logic [DW-1:0] wdata,
                         input int exp_w, input logic [DW-1:0] exp_res,
                         input int acc_d, input int lat, input int rsp_d, input bit keep);
        logic [N-1:0] oh;
        int t;
        oh = N'(1) << exp_w;
        eng_acc_delay = acc_d;
        eng_lat = lat;
        @(negedge clk);
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = (i == exp_w) ? wdata : DW'($urandom);
        bus.req_valid = mask;
        bus.rsp_ready = '0;
        #1;
        check("busy_idle", 64'(busy), 64'(0));
        check("req_ready_pick", 64'(bus.req_ready), 64'(oh));
        @(posedge clk);
        #1;
        check("grant_id", 64'(grant_id), 64'(exp_w));
        check("busy_issue", 64'(busy), 64'(1));
        check("eng_valid_in", 64'(eng_valid_in), 64'(1));
        check("eng_data_in", 64'(eng_data_in), 64'(wdata));
        bus.req_valid = keep ? mask : N'($urandom);
        bus.req_data  = {$urandom, $urandom};
        #1;
        check("req_ready_busy", 64'(bus.req_ready), 64'(0));
        t = 0;
        while (bus.rsp_valid == '0 && t < 200) begin
            @(negedge clk);
            t++;
            if (bus.rsp_valid == '0) begin
                check("busy_wait", 64'(busy), 64'(1));
                check("eng_ready_out", 64'(eng_ready_out), 64'(!eng_valid_in));
                if (eng_valid_in) check("eng_data_stable", 64'(eng_data_in), 64'(wdata));
            end
            if (!keep) bus.req_valid = N'($urandom);
            bus.req_data = {$urandom, $urandom};
        end
        if (t >= 200) begin
            check("rsp_valid_timeout", 64'(bus.rsp_valid), 64'(oh));
            bus.req_valid = '0;
            return;
        end
        check("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
        check("rsp_data", 64'(bus.rsp_data), 64'(exp_res));
        check("eng_ready_out_resp", 64'(eng_ready_out), 64'(0));
        for (int k = 0; k < rsp_d; k++) begin
            bus.rsp_ready = N'($urandom) & ~oh;
            if (!keep) bus.req_valid = N'($urandom);
            @(negedge clk);
            check("rsp_valid_held", 64'(bus.rsp_valid), 64'(oh));
            check("rsp_data_held", 64'(bus.rsp_data), 64'(exp_res));
            check("req_ready_resp", 64'(bus.req_ready), 64'(0));
            check("busy_resp", 64'(busy), 64'(1));
        end
        bus.rsp_ready = oh | (N'($urandom) & ~oh);
        bus.req_valid = keep ? mask : '0;
        @(posedge clk);
        #1;
        bus.rsp_ready = '0;
        m_last = exp_w;
        m_ops++;
        check("rsp_valid_clear", 64'(bus.rsp_valid), 64'(0));
        check("busy_done", 64'(busy), 64'(0));
        check("op_count", 64'(op_count), 64'(exp_opc()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_last = N - 1;
        m_ops  = 0;
    endtask

    typedef struct {
        logic [N-1:0]  mask;
        logic [DW-1:0] data;
        int            acc_d;
        int            lat;
        int            rsp_d;
        int            exp_w;
        logic [DW-1:0] exp_res;
    } vec_t;

    vec_t vecs [8];
    int   rot_order [5];

    initial begin
        int t;
        logic [N-1:0] mask;
        logic [DW-1:0] d;

        vecs[0] = '{4'b0001, 16'h0008, 0, 0, 0,  0, 16'h0016};
        vecs[1] = '{4'b1111, 16'h0100, 5, 1, 0,  1, 16'h0004};
        vecs[2] = '{4'b1001, 16'h0010, 1, 3, 10, 3, 16'h0010};
        vecs[3] = '{4'b0011, 16'h0040, 0, 0, 1,  0, 16'h0008};
        vecs[4] = '{4'b0100, 16'h0004, 2, 0, 0,  2, 16'h0020};
        vecs[5] = '{4'b0110, 16'h0024, 0, 2, 2,  1, 16'h000A};
        vecs[6] = '{4'b1000, 16'h0001, 0, 0, 0,  3, 16'h0040};
        vecs[7] = '{4'b1111, 16'h0090, 3, 4, 3,  0, 16'h0005};
        rot_order = '{0, 1, 2, 3, 0};

        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.rsp_ready = '0;
        rst_n = 1'b0;
        #12;
        check_zero("reset");
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            serve(vecs[i].mask, vecs[i].data, vecs[i].exp_w, vecs[i].exp_res,
                  vecs[i].acc_d, vecs[i].lat, vecs[i].rsp_d, 1'b0);
        end

        // All requesters continuously valid from reset: strict rotation.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            d = DW'($urandom_range(1, 16'hFFFF));
            serve(4'b1111, d, rot_order[k], ref_isqrt(d), 0, $urandom_range(0, 2), 0, k != 4);
        end
        check("op_count_rotation", 64'(op_count), 64'(EXP_ROT_OPC));

        // Reset while the engine is working, then requester 0 beats 3.
        eng_lat = 30;
        eng_acc_delay = 0;
        @(negedge clk);
        bus.req_data = {$urandom, $urandom};
        bus.req_valid = 4'b0010;
        #1;
        check("pre_rst_pick", 64'(bus.req_ready), 64'(4'b0010));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        t = 0;
        while (!eng_ready_out && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("wait_reached", 64'(eng_ready_out), 64'(1));
        #2;
        rst_n = 1'b0;
        bus.req_valid = 4'b1001;
        #1;
        check_zero("rst_mid");
        repeat (2) @(negedge clk);
        check_zero("rst_hold");
        rst_n = 1'b1;
        bus.req_valid = '0;
        m_last = N - 1;
        m_ops  = 0;
        d = 16'h0019;
        serve(4'b1001, d, 0, 16'h000C, 0, 0, 0, 1'b0);
        d = 16'h0031;
        serve(4'b1001, d, 3, 16'h0009, 0, 1, 0, 1'b0);

        // Randomized traffic against the rotation model.
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.req_valid = '0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check("idle_busy", 64'(busy), 64'(0));
                    check("idle_req_ready", 64'(bus.req_ready), 64'(0));
                end
            end
            mask = N'($urandom_range(1, 15));
            d = DW'($urandom);
            serve(mask, d, model_pick(mask), ref_isqrt(d), $urandom_range(0, 3),
                  $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
